gate_bist_ctrl: RTL and testbench

- Built-in self-test sequencer for a single-output combinational gate cell (inverter, NAND, NOR and similar) in the gate-level library.
- Drives every input vector to the gate in order and holds each vector for a programmable settle time.
- Samples the gate output and compares it with a parameterised truth table, then reports the error count, first failing vector and a pass/fail flag.
- Sits beside the cell under test and replaces hand-written stimulus sequences in the cell benches.

---
 rtl/gate_bist_ctrl_if.sv | 26 ++
 rtl/gate_bist_ctrl.sv | 104 ++++++++++
 tb/tb_gate_bist_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_bist_ctrl_if.sv
// Control/result bundle between a gate BIST sequencer and whatever drives it.
// The cell-under-test pins (dut_in/dut_out) ride along so one port carries the whole test.
interface gate_bist_ctrl_if #(
    parameter int N = 1
);
    logic         start;
    logic         abort;
    logic         dut_out;
    logic [N-1:0] dut_in;
    logic         busy;
    logic         done;
    logic         pass;
    logic [N:0]   err_count;
    logic         fail_seen;
    logic [N-1:0] first_fail;

    modport master (
        output start, abort, dut_out,
        input  dut_in, busy, done, pass, err_count, fail_seen, first_fail
    );

    modport slave (
        input  start, abort, dut_out,
        output dut_in, busy, done, pass, err_count, fail_seen, first_fail
    );
endinterface

// File: rtl/gate_bist_ctrl.sv
// Exhaustive BIST sequencer for a single-output N-input gate: walks all 2^N vectors,
// holds each SETTLE cycles, then checks the sampled output against TRUTH.
module gate_bist_ctrl #(
    parameter int                 N      = 1,
    parameter int                 SETTLE = 2,
    parameter logic [(1<<N)-1:0]  TRUTH  = 2'b01
) (
    input  logic             clk,
    input  logic             clrn,
    gate_bist_ctrl_if.slave  bus
);
    localparam int           WW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(SETTLE - 1);
    localparam logic [N-1:0] LAST_VEC  = '1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  dut_in_q, dut_in_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [N:0]    err_q, err_d;
    logic          fs_q, fs_d;
    logic [N-1:0]  ff_q, ff_d;
    logic          mismatch;

    assign mismatch = (bus.dut_out != TRUTH[dut_in_q]);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= S_IDLE;
            dut_in_q <= '0;
            wait_q   <= '0;
            err_q    <= '0;
            fs_q     <= 1'b0;
            ff_q     <= '0;
        end else begin
            state_q  <= state_d;
            dut_in_q <= dut_in_d;
            wait_q   <= wait_d;
            err_q    <= err_d;
            fs_q     <= fs_d;
            ff_q     <= ff_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dut_in_d = dut_in_q;
        wait_d   = wait_q;
        err_d    = err_q;
        fs_d     = fs_q;
        ff_d     = ff_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                // abort outranks start so an abort+start pair cannot launch a run
                if (bus.start && !bus.abort) begin
                    state_d  = S_SETTLE;
                    dut_in_d = '0;
                    wait_d   = '0;
                    err_d    = '0;
                    fs_d     = 1'b0;
                    ff_d     = '0;
                end
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (wait_q == WAIT_LAST) state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    if (mismatch) begin
                        err_d = err_q + 1'b1;
                        if (!fs_q) begin
                            fs_d = 1'b1;
                            ff_d = dut_in_q;
                        end
                    end
                    if (dut_in_q == LAST_VEC) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_SETTLE;
                        dut_in_d = dut_in_q + 1'b1;
                        wait_d   = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.dut_in     = dut_in_q;
    assign bus.busy       = (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign bus.done       = (state_q == S_DONE);
    assign bus.pass       = (state_q == S_DONE) && (err_q == '0);
    assign bus.err_count  = err_q;
    assign bus.fail_seen  = fs_q;
    assign bus.first_fail = ff_q;
endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: an inverter instance (N=1) and a NAND2 instance (N=2),
// each driving a behavioural gate model with optional stuck-at fault.
module tb_gate_bist_ctrl;
    localparam int SETTLE = 2;

    logic clk;
    logic clrn;
    logic inv_stuck0;
    logic nand_stuck1;

    gate_bist_ctrl_if #(.N(1)) b0 ();
    gate_bist_ctrl_if #(.N(2)) b1 ();

    gate_bist_ctrl #(.N(1), .SETTLE(SETTLE), .TRUTH(2'b01)) u_inv (
        .clk(clk), .clrn(clrn), .bus(b0)
    );
    gate_bist_ctrl #(.N(2), .SETTLE(SETTLE), .TRUTH(4'b0111)) u_nand (
        .clk(clk), .clrn(clrn), .bus(b1)
    );

    assign b0.dut_out = inv_stuck0  ? 1'b0 : ~b0.dut_in[0];
    assign b1.dut_out = nand_stuck1 ? 1'b1 : ~&b1.dut_in;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int err;
        int ff;
        int fs;
        int pass;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 good inverter, 1 inverter stuck-at-0, 2 good NAND2, 3 NAND2 stuck-at-1
    function automatic exp_t model(input int kind);
        exp_t       e;
        int         n;
        logic [3:0] tt;
        logic       g;
        n  = (kind < 2) ? 1 : 2;
        tt = (kind < 2) ? 4'b0001 : 4'b0111;
        e.err = 0; e.ff = 0; e.fs = 0;
        for (int v = 0; v < (1 << n); v++) begin
            case (kind)
                0:       g = (v == 0);
                1:       g = 1'b0;
                2:       g = (v != 3);
                default: g = 1'b1;
            endcase
            if (g != tt[v]) begin
                if (e.fs == 0) begin
                    e.fs = 1;
                    e.ff = v;
                end
                e.err++;
            end
        end
        e.pass = (e.err == 0);
        e.lat  = (1 << n) * (SETTLE + 1);
        return e;
    endfunction

    // Waits for done counting edges from E (caller is already 'from' edges past E), then pops and compares.
    task automatic finish_run(input int which, input int from);
        exp_t e;
        int   k;
        int   lat;
        lat = -1;
        for (k = from + 1; k <= from + 60; k++) begin
            tick();
            if ((which == 0) ? b0.done : b1.done) begin
                lat = k;
                break;
            end
        end
        e = sb.pop_front();
        chk("done_latency", 32'(lat), 32'(e.lat));
        if (which == 0) begin
            chk("inv_err_count",  32'(b0.err_count),  32'(e.err));
            chk("inv_first_fail", 32'(b0.first_fail), 32'(e.ff));
            chk("inv_fail_seen",  32'(b0.fail_seen),  32'(e.fs));
            chk("inv_pass",       32'(b0.pass),       32'(e.pass));
            chk("inv_busy_done",  32'(b0.busy),       32'(0));
        end else begin
            chk("nand_err_count",  32'(b1.err_count),  32'(e.err));
            chk("nand_first_fail", 32'(b1.first_fail), 32'(e.ff));
            chk("nand_fail_seen",  32'(b1.fail_seen),  32'(e.fs));
            chk("nand_pass",       32'(b1.pass),       32'(e.pass));
            chk("nand_busy_done",  32'(b1.busy),       32'(0));
        end
    endtask

    task automatic run_inv(input bit stuck, input bit hold);
        inv_stuck0 = stuck;
        sb.push_back(model(stuck ? 1 : 0));
        b0.start = 1'b1;
        tick();
        if (!hold) b0.start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk("inv_busy_run", 32'(b0.busy),   32'(1));
            chk("inv_vec_hold", 32'(b0.dut_in), 32'(c / 3));
            if (c < 5) tick();
        end
        finish_run(0, 5);
    endtask

    initial begin
        clrn = 1'b0;
        b0.start = 1'b0; b0.abort = 1'b0;
        b1.start = 1'b0; b1.abort = 1'b0;
        inv_stuck0 = 1'b0; nand_stuck1 = 1'b0;
        #23 clrn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick();
            chk("reset_inv", 32'({b0.busy, b0.done, b0.pass, b0.fail_seen,
                                  b0.err_count, b0.first_fail, b0.dut_in}), 32'(0));
            chk("reset_nand", 32'({b1.busy, b1.done, b1.pass, b1.fail_seen,
                                   b1.err_count, b1.first_fail, b1.dut_in}), 32'(0));
        end

        run_inv(1'b0, 1'b0);
        run_inv(1'b1, 1'b0);

        // NAND2 stuck-at-1, then restart from DONE with a healthy gate
        nand_stuck1 = 1'b1;
        sb.push_back(model(3));
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        chk("nand_busy_start", 32'(b1.busy), 32'(1));
        finish_run(1, 0);
        nand_stuck1 = 1'b0;
        sb.push_back(model(2));
        b1.start = 1'b1;
        tick();
        b1.start = 1'b0;
        chk("nand_restart_err",  32'(b1.err_count), 32'(0));
        chk("nand_restart_done", 32'(b1.done),      32'(0));
        chk("nand_restart_busy", 32'(b1.busy),      32'(1));
        chk("nand_restart_fs",   32'(b1.fail_seen), 32'(0));
        finish_run(1, 0);

        // abort during SETTLE of vector 1: partial results kept, no done
        inv_stuck0 = 1'b1;
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        b0.abort = 1'b1;
        tick();
        b0.abort = 1'b0;
        chk("abort_busy", 32'(b0.busy),       32'(0));
        chk("abort_err",  32'(b0.err_count),  32'(1));
        chk("abort_fs",   32'(b0.fail_seen),  32'(1));
        chk("abort_ff",   32'(b0.first_fail), 32'(0));
        begin
            logic any_done;
            any_done = 1'b0;
            for (int i = 0; i < 10; i++) begin
                tick();
                any_done |= b0.done | b0.busy;
            end
            chk("abort_no_done", 32'(any_done), 32'(0));
        end

        // abort in CHECK of vector 0: that compare must not count
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        tick();
        tick();
        b0.abort = 1'b1;
        tick();
        b0.abort = 1'b0;
        chk("abort_check_err",  32'(b0.err_count), 32'(0));
        chk("abort_check_fs",   32'(b0.fail_seen), 32'(0));
        chk("abort_check_busy", 32'(b0.busy),      32'(0));

        // abort+start together in IDLE: abort wins
        b0.start = 1'b1;
        b0.abort = 1'b1;
        tick();
        b0.start = 1'b0;
        b0.abort = 1'b0;
        chk("abort_start_idle", 32'(b0.busy), 32'(0));

        // asynchronous reset mid-run
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        tick();
        tick();
        #2 clrn = 1'b0;
        #1;
        chk("async_reset_inv", 32'({b0.busy, b0.done, b0.pass, b0.fail_seen,
                                    b0.err_count, b0.first_fail, b0.dut_in}), 32'(0));
        chk("async_reset_nand", 32'({b1.busy, b1.done, b1.pass, b1.fail_seen,
                                     b1.err_count, b1.first_fail, b1.dut_in}), 32'(0));
        #1 clrn = 1'b1;
        tick();
        chk("post_reset_idle", 32'(b0.busy | b0.done), 32'(0));

        // start held high through the whole run: restarts only from DONE
        run_inv(1'b0, 1'b1);
        tick();
        chk("hold_restart_busy", 32'(b0.busy),   32'(1));
        chk("hold_restart_done", 32'(b0.done),   32'(0));
        chk("hold_restart_vec",  32'(b0.dut_in), 32'(0));
        b0.start = 1'b0;
        b0.abort = 1'b1;
        tick();
        b0.abort = 1'b0;
        chk("scoreboard_empty", 32'(sb.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
